// File: rtl/ropuf_array_if.sv
// ropuf_array_if: request/response bundle for the RO-PUF array.
//   start, chal, resp_ack       : consumer -> array
//   ro_en, busy                 : array status
//   resp_valid, resp, resp_tie  : evaluation result, held until resp_ack
//   margin_mask                 : only with ROPUF_MARGIN_EN defined
// Modports: master = consumer side, slave = the array.
interface ropuf_array_if #(
  parameter int N_BITS = 4,
  parameter int SEL_W  = 2
);
  logic                      start;
  logic [N_BITS*SEL_W-1:0]   chal;
  logic                      resp_ack;
  logic                      ro_en;
  logic                      busy;
  logic                      resp_valid;
  logic [N_BITS-1:0]         resp;
  logic [N_BITS-1:0]         resp_tie;
`ifdef ROPUF_MARGIN_EN
  logic [N_BITS-1:0]         margin_mask;
`endif

  modport master (
    output start, chal, resp_ack,
    input  ro_en, busy, resp_valid, resp, resp_tie
`ifdef ROPUF_MARGIN_EN
    , input margin_mask
`endif
  );

  modport slave (
    input  start, chal, resp_ack,
    output ro_en, busy, resp_valid, resp, resp_tie
`ifdef ROPUF_MARGIN_EN
    , output margin_mask
`endif
  );
endinterface

// File: rtl/ropuf_array.sv
// ropuf_array: ring-oscillator PUF. For each response bit one RO per side
// (A/B) is selected by the challenge, its edges are counted over a fixed
// window, and the two counts are compared.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   ro_in  : oscillator outputs, index (i*2+s)*2^SEL_W+k (s=0 A, s=1 B)
//   bus    : ropuf_array_if.slave (start/chal/resp_ack in, status/result out)
// Optional: define ROPUF_MARGIN_EN to add bus.margin_mask, set for bits
// whose count difference is below MARGIN_TH.
//
// state   | meaning
// IDLE    | waiting for start; chal latched and counters cleared on accept
// SETTLE  | ROs enabled, SETTLE_CYC cycles discarded
// MEASURE | WIN_CYC cycles of edge counting
// COMPARE | one cycle; resp/resp_tie registered on exit
// DONE    | resp_valid raised, waiting for resp_ack
module ropuf_array #(
  parameter int N_BITS     = 4,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 16,
  parameter int MARGIN_TH  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [2*N_BITS*(1<<SEL_W)-1:0]    ro_in,
  ropuf_array_if.slave                      bus
);
  localparam int K       = 1 << SEL_W;
  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [TMR_W-1:0]          tmr_q, tmr_val;
  logic                      tmr_load;
  logic [N_BITS*SEL_W-1:0]   chal_q;
  logic                      start_acc;
  logic                      valid_q;
  logic                      ro_en, busy;
  logic [N_BITS-1:0]         resp_q, tie_q, gt, eq;
  logic [2*N_BITS*CNT_W-1:0] cnt_flat;

  assign start_acc = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    ro_en    = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = SETTLE;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        ro_en = 1'b1;
        if (tmr_q == '0) begin
          state_d  = MEASURE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(WIN_CYC - 1);
        end
      end
      MEASURE: begin
        ro_en = 1'b1;
        if (tmr_q == '0) state_d = COMPARE;
      end
      COMPARE: state_d = DONE;
      DONE: if (valid_q && bus.resp_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase timer: down-counter, terminal count at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         tmr_q <= '0;
    else if (tmr_load)  tmr_q <= tmr_val;
    else if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         chal_q <= '0;
    else if (start_acc) chal_q <= bus.chal;
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_bit
    for (genvar s = 0; s < 2; s++) begin : g_side
      logic [K-1:0]     bank;
      logic             sel;
      logic [2:0]       sh;   // [0],[1] synchronizer, [2] previous sample
      logic [CNT_W-1:0] cnt;

      assign bank = ro_in[(i*2+s)*K +: K];
      assign sel  = bank[chal_q[i*SEL_W +: SEL_W]];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sh  <= '0;
          cnt <= '0;
        end else begin
          sh <= {sh[1:0], sel};
          if (start_acc)
            cnt <= '0;
          else if (state_q == MEASURE && sh[1] && !sh[2] && cnt != '1)
            cnt <= cnt + 1'b1;
        end
      end

      assign cnt_flat[(i*2+s)*CNT_W +: CNT_W] = cnt;
    end

    logic [CNT_W-1:0] ca, cb;
    assign ca    = cnt_flat[(i*2)*CNT_W +: CNT_W];
    assign cb    = cnt_flat[(i*2+1)*CNT_W +: CNT_W];
    assign gt[i] = (ca > cb);
    assign eq[i] = (ca == cb);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_q <= '0;
      tie_q  <= '0;
    end else if (state_q == COMPARE) begin
      resp_q <= gt;
      tie_q  <= eq;
    end
  end

  // resp_valid rises one edge after DONE is entered, so resp is already
  // stable when the consumer sees valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= 1'b0;
    else        valid_q <= (state_q == DONE) && !(valid_q && bus.resp_ack);
  end

`ifdef ROPUF_MARGIN_EN
  logic [N_BITS-1:0] near, margin_q;
  for (genvar i = 0; i < N_BITS; i++) begin : g_margin
    logic [CNT_W-1:0] diff;
    assign diff    = gt[i] ? (g_bit[i].ca - g_bit[i].cb) : (g_bit[i].cb - g_bit[i].ca);
    assign near[i] = (32'(diff) < MARGIN_TH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  margin_q <= '0;
    else if (state_q == COMPARE) margin_q <= near;
  end

  assign bus.margin_mask = margin_q;
`endif

  assign bus.ro_en      = ro_en;
  assign bus.busy       = busy;
  assign bus.resp_valid = valid_q;
  assign bus.resp       = resp_q;
  assign bus.resp_tie   = tie_q;
endmodule
